// File: rtl/pa_pkg.sv
// Shared definitions for the PE-array result path: tile geometry and the
// writeback FSM state encoding.
package pa_pkg;

    localparam int NUM_LANES  = 4;
    localparam int NUM_ROWS   = 4;
    localparam int DATA_W     = 32;
    localparam int TILE_WORDS = NUM_LANES * NUM_ROWS;
    localparam int IDX_W      = $clog2(TILE_WORDS);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEL  = 3'd1,
        CAP  = 3'd2,
        SEND = 3'd3,
        FIN  = 3'd4
    } state_t;

endpackage

// File: rtl/rwb_tile_buffer.sv
// Tile buffer for result_writeback: one full row of lanes written per cycle
// (with optional ReLU), one word read combinationally by flat row-major index.
module rwb_tile_buffer
    import pa_pkg::*;
#(
    parameter int DW    = DATA_W,
    parameter int LANES = NUM_LANES,
    parameter int ROWS  = NUM_ROWS
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(ROWS)-1:0]  wr_row,
    input  logic                     relu,
    input  logic [LANES*DW-1:0]      wr_lanes,
    input  logic [$clog2(ROWS*LANES)-1:0] rd_idx,
    output logic [DW-1:0]            rd_data
);

    localparam int LW = $clog2(LANES);
    localparam int IW = $clog2(ROWS * LANES);

    // Contents are don't-care until written, so the storage carries no reset.
    logic [LANES*DW-1:0] row_mem [ROWS];

    logic [IW-LW-1:0] rd_row;
    logic [LW-1:0]    rd_lane;

    function automatic logic signed [DW-1:0] relu_word(input logic signed [DW-1:0] v,
                                                       input logic en);
        if (en && (v < 0)) begin
            return '0;
        end
        return v;
    endfunction

    function automatic logic [LANES*DW-1:0] relu_row(input logic [LANES*DW-1:0] row,
                                                     input logic en);
        logic [LANES*DW-1:0] res;
        logic signed [DW-1:0] lane;
        res = '0;
        for (int i = 0; i < LANES; i++) begin
            lane = row[i*DW +: DW];
            res[i*DW +: DW] = relu_word(lane, en);
        end
        return res;
    endfunction

    always_ff @(posedge clk) begin
        if (wr_en) begin
            row_mem[wr_row] <= relu_row(wr_lanes, relu);
        end
    end

    assign rd_row  = rd_idx[IW-1:LW];
    assign rd_lane = rd_idx[LW-1:0];

    always_comb begin
        rd_data = row_mem[rd_row][rd_lane*DW +: DW];
    end

endmodule

// File: rtl/result_writeback.sv
// Drains the 4x4 accumulator tile from the PE arrays row by row via out_sel,
// then streams the buffered words to memory over write_rdy/write_acq.
module result_writeback
    import pa_pkg::*;
#(
    parameter int DW      = DATA_W,
    parameter int LANES   = NUM_LANES,
    parameter int ROWS    = NUM_ROWS,
    parameter int SEL_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                relu_en,
    input  logic [LANES*DW-1:0] result_flat,
    output logic [ROWS-1:0]     out_sel,
    output logic                busy,
    output logic [DW-1:0]       wr_data,
    output logic                write_rdy,
    input  logic                write_acq,
    output logic                done,
    output logic [15:0]         tile_cnt
);

    localparam int TILE = ROWS * LANES;
    localparam int IW   = $clog2(TILE);
    localparam int RW   = $clog2(ROWS);

    localparam logic [1:0]    WAIT_LAST = 2'((SEL_LAT > 0) ? SEL_LAT - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST  = IW'(TILE - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
    // With zero select latency the result is already valid when out_sel is
    // driven, so each row goes straight to capture.
    localparam state_t ROW_ENTRY = (SEL_LAT == 0) ? CAP : SEL;

    state_t        state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [1:0]    wait_q, wait_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          relu_q, relu_d;
    logic [15:0]   tile_cnt_q;

    logic          cap_en;
    logic [ROWS-1:0] sel_oh;
    logic [DW-1:0] rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            row_q      <= '0;
            wait_q     <= '0;
            idx_q      <= '0;
            relu_q     <= 1'b0;
            tile_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            wait_q  <= wait_d;
            idx_q   <= idx_d;
            relu_q  <= relu_d;
            if (state_q == FIN) begin
                tile_cnt_q <= tile_cnt_q + 16'd1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        wait_d    = wait_q;
        idx_d     = idx_q;
        relu_d    = relu_q;
        cap_en    = 1'b0;
        out_sel   = '0;
        busy      = 1'b0;
        write_rdy = 1'b0;
        done      = 1'b0;
        sel_oh    = '0;
        sel_oh[row_q] = 1'b1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    relu_d  = relu_en;
                    row_d   = '0;
                    wait_d  = '0;
                    idx_d   = '0;
                    state_d = ROW_ENTRY;
                end
            end
            SEL: begin
                busy    = 1'b1;
                out_sel = sel_oh;
                if (wait_q == WAIT_LAST) begin
                    wait_d  = '0;
                    state_d = CAP;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            CAP: begin
                busy    = 1'b1;
                out_sel = sel_oh;
                cap_en  = 1'b1;
                if (row_q == ROW_LAST) begin
                    row_d   = '0;
                    idx_d   = '0;
                    state_d = SEND;
                end else begin
                    row_d   = row_q + 1'b1;
                    state_d = ROW_ENTRY;
                end
            end
            SEND: begin
                busy      = 1'b1;
                write_rdy = 1'b1;
                if (write_acq) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = FIN;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // wr_data follows the buffer only while offering a word, so it holds
    // steady under backpressure and reads as zero otherwise.
    always_comb begin
        wr_data = (state_q == SEND) ? rd_data : '0;
    end

    assign tile_cnt = tile_cnt_q;

    rwb_tile_buffer #(
        .DW    (DW),
        .LANES (LANES),
        .ROWS  (ROWS)
    ) u_tile_buffer (
        .clk      (clk),
        .wr_en    (cap_en),
        .wr_row   (row_q),
        .relu     (relu_q),
        .wr_lanes (result_flat),
        .rd_idx   (idx_q),
        .rd_data  (rd_data)
    );

endmodule

// File: tb/tb_result_writeback.sv
// Bench for result_writeback: a PE-array model feeds tile values, a scoreboard
// queue holds expected words and a negedge monitor compares each transfer.
module tb_result_writeback;

    localparam int SEL_LAT   = 1;
    localparam int FIRST_RDY = 4 * (SEL_LAT + 1) + 1;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         relu_en;
    logic [127:0] result_flat;
    logic [3:0]   out_sel;
    logic         busy;
    logic [31:0]  wr_data;
    logic         write_rdy;
    logic         write_acq;
    logic         done;
    logic [15:0]  tile_cnt;

    int checks;
    int failures;

    logic [511:0] tile_vals;
    logic [31:0]  exp_q[$];
    logic [15:0]  exp_cnt;

    logic         prev_stall;
    logic [31:0]  prev_data;

    result_writeback #(
        .DW      (32),
        .LANES   (4),
        .ROWS    (4),
        .SEL_LAT (SEL_LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .relu_en     (relu_en),
        .result_flat (result_flat),
        .out_sel     (out_sel),
        .busy        (busy),
        .wr_data     (wr_data),
        .write_rdy   (write_rdy),
        .write_acq   (write_acq),
        .done        (done),
        .tile_cnt    (tile_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PE-array model: result reflects out_sel one cycle after it changes.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            case (out_sel)
                4'b0001: result_flat[32*i +: 32] <= tile_vals[32*(0 + i) +: 32];
                4'b0010: result_flat[32*i +: 32] <= tile_vals[32*(4 + i) +: 32];
                4'b0100: result_flat[32*i +: 32] <= tile_vals[32*(8 + i) +: 32];
                4'b1000: result_flat[32*i +: 32] <= tile_vals[32*(12 + i) +: 32];
                default: result_flat[32*i +: 32] <= 32'hDEADBEEF;
            endcase
        end
    end

    // Scoreboard monitor: every accepted word is popped and compared.
    always @(negedge clk) begin
        logic [31:0] exp_w;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!write_rdy || wr_data !== prev_data) begin
                    failures++;
                    $display("FAIL stall_hold: rdy=%0b data=%08h required rdy=1 data=%08h",
                             write_rdy, wr_data, prev_data);
                end
            end
            if (write_rdy && write_acq) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL extra_word: got %08h with no word expected", wr_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (wr_data !== exp_w) begin
                        failures++;
                        $display("FAIL word_data: got %08h required %08h", wr_data, exp_w);
                    end
                end
            end
            prev_stall = write_rdy && !write_acq;
            prev_data  = wr_data;
        end
    end

    task automatic set_tile(input int mode);
        for (int k = 0; k < 16; k++) begin
            case (mode)
                0:       tile_vals[32*k +: 32] = 32'(256 * (k / 4) + (k % 4));
                1: begin
                    case (k % 4)
                        0:       tile_vals[32*k +: 32] = 32'hFFFFFFFF;
                        1:       tile_vals[32*k +: 32] = 32'h80000000;
                        2:       tile_vals[32*k +: 32] = 32'h00000000;
                        default: tile_vals[32*k +: 32] = 32'h7FFFFFFF;
                    endcase
                end
                default: tile_vals[32*k +: 32] = $urandom;
            endcase
        end
    endtask

    task automatic push_expect(input logic relu);
        logic [31:0] v;
        for (int k = 0; k < 16; k++) begin
            v = tile_vals[32*k +: 32];
            exp_q.push_back((relu && v[31]) ? 32'h0 : v);
        end
    endtask

    // Drives one tile from its start pulse to done and reports what it saw.
    task automatic run_tile(input logic relu, input int acq_mode, input int extra_start,
                            output int first_rdy, output int done_c, output int xfers,
                            output logic [15:0] sel_seq, output int sel_n);
        logic [3:0] prev_sel;
        logic [3:0] pat;
        int k;
        pat       = 4'b1001;
        first_rdy = -1;
        done_c    = -1;
        xfers     = 0;
        sel_seq   = '0;
        sel_n     = 0;
        prev_sel  = '0;
        push_expect(relu);
        for (int c = 0; c < 600 && done_c < 0; c++) begin
            @(posedge clk);
            #1;
            start   = (c == 0) || (extra_start >= 0 && first_rdy >= 0 && c == first_rdy + extra_start);
            relu_en = (c == 0) ? relu : ~relu;
            k = c - FIRST_RDY;
            if (acq_mode == 0)
                write_acq = 1'b1;
            else if (k >= 0 && k < 4)
                write_acq = pat[k[1:0]];
            else
                write_acq = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (out_sel != prev_sel && out_sel != 4'b0000) begin
                if (sel_n < 4) sel_seq[4*sel_n +: 4] = out_sel;
                sel_n++;
            end
            prev_sel = out_sel;
            if (write_rdy && first_rdy < 0) first_rdy = c;
            if (write_rdy && write_acq) xfers++;
            if (done) done_c = c;
        end
        start     = 1'b0;
        write_acq = 1'b1;
        if (done_c >= 0) exp_cnt++;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (out_sel !== 4'b0)   begin failures++; $display("FAIL reset_out_sel: got %0h required 0", out_sel); end
        checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy: got %0b required 0", busy); end
        checks++; if (wr_data !== 32'h0)  begin failures++; $display("FAIL reset_wr_data: got %08h required 0", wr_data); end
        checks++; if (write_rdy !== 1'b0) begin failures++; $display("FAIL reset_write_rdy: got %0b required 0", write_rdy); end
        checks++; if (done !== 1'b0)      begin failures++; $display("FAIL reset_done: got %0b required 0", done); end
        checks++; if (tile_cnt !== 16'h0) begin failures++; $display("FAIL reset_tile_cnt: got %0h required 0", tile_cnt); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %0b required 0", busy); end
    endtask

    task automatic test_basic();
        int fr, dc, xf, sn;
        logic [15:0] ss;
        set_tile(0);
        run_tile(1'b0, 0, -1, fr, dc, xf, ss, sn);
        checks++; if (sn != 4)          begin failures++; $display("FAIL basic_sel_count: got %0d required 4", sn); end
        checks++; if (ss !== 16'h8421)  begin failures++; $display("FAIL basic_sel_seq: got %04h required 8421", ss); end
        checks++; if (fr != FIRST_RDY)  begin failures++; $display("FAIL basic_first_rdy: got %0d required %0d", fr, FIRST_RDY); end
        checks++; if (dc != FIRST_RDY + 16) begin failures++; $display("FAIL basic_done_cycle: got %0d required %0d", dc, FIRST_RDY + 16); end
        checks++; if (xf != 16)         begin failures++; $display("FAIL basic_xfers: got %0d required 16", xf); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL basic_after_done: done=%0b busy=%0b required 0 0", done, busy); end
        checks++; if (tile_cnt !== exp_cnt) begin failures++; $display("FAIL basic_tile_cnt: got %0h required %0h", tile_cnt, exp_cnt); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL basic_left: got %0d words outstanding required 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        int fr, dc, xf, sn;
        logic [15:0] ss;
        set_tile(2);
        run_tile(1'b0, 1, -1, fr, dc, xf, ss, sn);
        checks++; if (dc < 0)   begin failures++; $display("FAIL bp_timeout: done_cycle=%0d required >=0", dc); end
        checks++; if (xf != 16) begin failures++; $display("FAIL bp_xfers: got %0d required 16", xf); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL bp_left: got %0d words outstanding required 0", exp_q.size()); end
        @(negedge clk);
    endtask

    task automatic test_relu();
        int fr, dc, xf, sn;
        logic [15:0] ss;
        set_tile(1);
        run_tile(1'b1, 0, -1, fr, dc, xf, ss, sn);
        checks++; if (xf != 16) begin failures++; $display("FAIL relu_xfers: got %0d required 16", xf); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL relu_left: got %0d words outstanding required 0", exp_q.size()); end
        @(negedge clk);
    endtask

    task automatic test_start_busy();
        int fr, dc, xf, sn;
        logic [15:0] ss;
        set_tile(2);
        run_tile(1'b0, 0, 3, fr, dc, xf, ss, sn);
        checks++; if (xf != 16) begin failures++; $display("FAIL busy_start_xfers: got %0d required 16", xf); end
        checks++; if (dc != FIRST_RDY + 16) begin failures++; $display("FAIL busy_start_done: got %0d required %0d", dc, FIRST_RDY + 16); end
        // start raised during the FIN cycle must be dropped
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL fin_start_busy: got %0b required 0", busy); end
        checks++; if (tile_cnt !== exp_cnt) begin failures++; $display("FAIL busy_start_tile_cnt: got %0h required %0h", tile_cnt, exp_cnt); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || out_sel !== 4'b0) begin failures++; $display("FAIL fin_start_idle: busy=%0b out_sel=%0h required 0 0", busy, out_sel); end
    endtask

    task automatic test_back_to_back();
        int fr, dc, xf, sn;
        logic [15:0] ss;
        logic r;
        for (int t = 0; t < 2; t++) begin
            set_tile(2);
            r = 1'($urandom_range(0, 1));
            run_tile(r, 0, -1, fr, dc, xf, ss, sn);
            checks++; if (fr != FIRST_RDY) begin failures++; $display("FAIL b2b_first_rdy: tile %0d got %0d required %0d", t, fr, FIRST_RDY); end
            checks++; if (xf != 16) begin failures++; $display("FAIL b2b_xfers: tile %0d got %0d required 16", t, xf); end
        end
        @(negedge clk);
        checks++; if (tile_cnt !== exp_cnt) begin failures++; $display("FAIL b2b_tile_cnt: got %0h required %0h", tile_cnt, exp_cnt); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_left: got %0d words outstanding required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_send();
        int n, fr, dc, xf, sn;
        logic [15:0] ss;
        set_tile(2);
        push_expect(1'b0);
        n = 0;
        @(posedge clk);
        #1 start = 1'b1; relu_en = 1'b0; write_acq = 1'b1;
        for (int c = 0; c < 100 && n < 5; c++) begin
            @(negedge clk);
            if (write_rdy && write_acq) n++;
            if (n < 5) begin
                @(posedge clk);
                #1 start = 1'b0;
            end
        end
        checks++; if (n != 5) begin failures++; $display("FAIL rst_mid_reach: got %0d words required 5", n); end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_sel !== 4'b0 || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rst_mid_ctrl: out_sel=%0h busy=%0b done=%0b required 0 0 0", out_sel, busy, done); end
        checks++; if (write_rdy !== 1'b0 || wr_data !== 32'h0) begin failures++; $display("FAIL rst_mid_data: rdy=%0b data=%08h required 0 0", write_rdy, wr_data); end
        checks++; if (tile_cnt !== 16'h0) begin failures++; $display("FAIL rst_mid_tile_cnt: got %0h required 0", tile_cnt); end
        exp_q.delete();
        exp_cnt = 16'h0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        set_tile(2);
        run_tile(1'b0, 0, -1, fr, dc, xf, ss, sn);
        checks++; if (fr != FIRST_RDY || xf != 16) begin failures++; $display("FAIL rst_mid_retile: first_rdy=%0d xfers=%0d required %0d 16", fr, xf, FIRST_RDY); end
        @(negedge clk);
        checks++; if (tile_cnt !== exp_cnt) begin failures++; $display("FAIL rst_mid_count: got %0h required %0h", tile_cnt, exp_cnt); end
    endtask

    task automatic test_tile_cnt_wrap();
        int fr, dc, xf, sn;
        logic [15:0] ss;
        force dut.tile_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.tile_cnt_q;
        @(negedge clk);
        checks++; if (tile_cnt !== 16'hFFFF) begin failures++; $display("FAIL wrap_preset: got %0h required ffff", tile_cnt); end
        set_tile(0);
        run_tile(1'b0, 0, -1, fr, dc, xf, ss, sn);
        @(negedge clk);
        checks++; if (tile_cnt !== 16'h0000) begin failures++; $display("FAIL wrap_tile_cnt: got %0h required 0000", tile_cnt); end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        exp_cnt    = 16'h0;
        prev_stall = 1'b0;
        prev_data  = 32'h0;
        rst_n      = 1'b0;
        start      = 1'b0;
        relu_en    = 1'b0;
        write_acq  = 1'b0;
        tile_vals  = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_relu();
        test_start_busy();
        test_back_to_back();
        test_reset_mid_send();
        test_tile_cnt_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
